// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and flag bit positions.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps per product.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // The multiplier sits in r_lo and is shifted out LSB-first as product bits shift in.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(WIDTH);
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
    end else if (r_busy && (r_cnt != '0)) begin
      r_hi <= w_sum[WIDTH:1];
      r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = {r_hi, r_lo};

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; single-cycle ops complete in one edge,
// MUL runs through the shift-add sub-module while the input side is held off.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_f;
  logic [WIDTH-1:0]   r_f_hi;
  logic [3:0]         r_flags;
  logic               w_accept;
  logic               w_start_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_f;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;
  logic [3:0]         w_mul_flags;
  logic [SHW-1:0]     w_shamt;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] fl;
    fl        = '0;
    fl[FLG_Z] = z;
    fl[FLG_N] = n;
    fl[FLG_C] = c;
    fl[FLG_V] = v;
    return fl;
  endfunction

  assign in_ready    = !rst && (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_start_mul = w_accept && (op == OP_MUL);
  assign w_shamt     = b[SHW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start_mul),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_add = {1'b0, a} + {1'b0, b};
    w_sub = {1'b0, a} - {1'b0, b};
    w_f   = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_f = w_add[WIDTH-1:0];
        w_c = w_add[WIDTH];
        w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_f = w_sub[WIDTH-1:0];
        w_c = w_sub[WIDTH];
        w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_f = a & b;
      OP_OR:   w_f = a | b;
      OP_XOR:  w_f = a ^ b;
      OP_SHL:  w_f = a << w_shamt;
      OP_SHR:  w_f = a >> w_shamt;
      default: w_f = '0;
    endcase
    w_flags     = pack_flags(w_f == '0, w_f[WIDTH-1], w_c, w_v);
    w_mul_flags = pack_flags(w_product == '0, w_product[2*WIDTH-1],
                             w_product[2*WIDTH-1:WIDTH] != '0, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_mul) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register: a new single-cycle result may overwrite one being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_f_hi      <= '0;
      r_flags     <= '0;
    end else if (w_accept && !w_start_mul) begin
      r_out_valid <= 1'b1;
      r_f         <= w_f;
      r_f_hi      <= '0;
      r_flags     <= w_flags;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_f         <= w_product[WIDTH-1:0];
      r_f_hi      <= w_product[2*WIDTH-1:WIDTH];
      r_flags     <= w_mul_flags;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign f_hi      = r_f_hi;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed scenarios plus a randomized scoreboard run.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] f;
  logic [7:0] f_hi;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] hi;
    logic [3:0] fl;
  } exp_t;

  exp_t q[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .f_hi      (f_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    int          r;
    int          sr;
    logic [15:0] p;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    e.hi = 8'h00;
    e.f  = 8'h00;
    c    = 1'b0;
    v    = 1'b0;
    p    = 16'h0000;
    case (o)
      OP_ADD: begin
        r   = int'(x) + int'(y);
        sr  = int'($signed(x)) + int'($signed(y));
        e.f = r[7:0];
        c   = (r > 255);
        v   = (sr > 127) || (sr < -128);
      end
      OP_SUB: begin
        r   = int'(x) - int'(y);
        sr  = int'($signed(x)) - int'($signed(y));
        e.f = r[7:0];
        c   = (x < y);
        v   = (sr > 127) || (sr < -128);
      end
      OP_AND: e.f = x & y;
      OP_OR:  e.f = x | y;
      OP_XOR: e.f = x ^ y;
      OP_SHL: e.f = x << y[2:0];
      OP_SHR: e.f = x >> y[2:0];
      default: begin
        p    = 16'(x) * 16'(y);
        e.f  = p[7:0];
        e.hi = p[15:8];
        c    = (p[15:8] != 8'h00);
      end
    endcase
    if (o == OP_MUL) begin
      z = (p == 16'h0000);
      n = p[15];
    end else begin
      z = (e.f == 8'h00);
      n = e.f[7];
    end
    e.fl = {z, n, c, v};
    return e;
  endfunction

  // Scoreboard: compare every result the consumer takes against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got f_hi/f=%h%h flags=%b, expected no output", f_hi, f, flags);
      end else begin
        e = q.pop_front();
        if ({f, f_hi, flags} !== {e.f, e.hi, e.fl}) begin
          failures++;
          $display("FAIL sb_result got f=%h f_hi=%h flags=%b want f=%h f_hi=%h flags=%b",
                   f, f_hi, flags, e.f, e.hi, e.fl);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int t;
    t        = 0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        q.push_back(model(o, x, y));
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout in_ready=%b want 1 within 100 cycles", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if ({out_valid, f, f_hi, flags} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b f=%h f_hi=%h flags=%b want all 0", out_valid, f, f_hi, flags);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_ops();
    logic [2:0] ops [4];
    logic [7:0] want [4];
    ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    want = '{8'h08, 8'hFC, 8'h02, 8'h06};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 8'h02, 8'h06);
      checks++;
      if (out_valid !== 1'b1 || f !== want[i]) begin
        failures++;
        $display("FAIL basic_op%0d got ov=%b f=%h want ov=1 f=%h", i, out_valid, f, want[i]);
      end
      if (ops[i] == OP_SUB) begin
        checks++;
        if (flags !== 4'b0110) begin
          failures++;
          $display("FAIL basic_sub_flags got=%b want=0110", flags);
        end
      end
    end
  endtask

  task automatic test_flag_corners();
    logic [2:0] ops [4];
    logic [7:0] xa [4];
    logic [7:0] xb [4];
    logic [7:0] wf [4];
    logic [3:0] wfl [4];
    ops = '{OP_ADD, OP_ADD, OP_SUB, OP_SHL};
    xa  = '{8'h7F, 8'hFF, 8'h80, 8'h81};
    xb  = '{8'h01, 8'h01, 8'h01, 8'h0B};
    wf  = '{8'h80, 8'h00, 8'h7F, 8'h08};
    wfl = '{4'b0101, 4'b1010, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], xa[i], xb[i]);
      checks++;
      if (out_valid !== 1'b1 || f !== wf[i] || flags !== wfl[i]) begin
        failures++;
        $display("FAIL flag_corner%0d got ov=%b f=%h flags=%b want ov=1 f=%h flags=%b",
                 i, out_valid, f, flags, wf[i], wfl[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n;
    int ir_bad;
    out_ready = 1'b1;
    send(OP_MUL, 8'hFF, 8'hFF);
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 8'h12;
    b        = 8'h34;
    n        = 0;
    ir_bad   = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      if (in_ready !== 1'b0) ir_bad++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL mul_latency got=%0d edges want=9", n);
    end
    checks++;
    if (ir_bad != 0) begin
      failures++;
      $display("FAIL mul_in_ready got %0d cycles ready want 0", ir_bad);
    end
    checks++;
    if ({f_hi, f} !== 16'hFE01 || flags !== 4'b0110) begin
      failures++;
      $display("FAIL mul_ffxff got=%h flags=%b want=FE01 flags=0110", {f_hi, f}, flags);
    end
    @(posedge clk); #1;
    send(OP_MUL, 8'h00, 8'h37);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 9 || {f_hi, f} !== 16'h0000 || flags !== 4'b1000) begin
      failures++;
      $display("FAIL mul_zero got lat=%0d val=%h flags=%b want lat=9 val=0000 flags=1000",
               n, {f_hi, f}, flags);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] f0;
    logic [3:0] fl0;
    int         bad;
    time        t0;
    bad       = 0;
    out_ready = 1'b0;
    send(OP_ADD, 8'h11, 8'h22);
    checks++;
    if (out_valid !== 1'b1 || f !== 8'h33) begin
      failures++;
      $display("FAIL bp_first got ov=%b f=%h want ov=1 f=33", out_valid, f);
    end
    f0       = f;
    fl0      = flags;
    op       = OP_ADD;
    a        = 8'h05;
    b        = 8'h03;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || f !== f0 || flags !== fl0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    t0 = $time;
    send(OP_ADD, 8'h05, 8'h03);
    checks++;
    if (out_valid !== 1'b1 || f !== 8'h08 || ($time - t0) != 10) begin
      failures++;
      $display("FAIL bp_no_bubble got ov=%b f=%h dt=%0t want ov=1 f=08 dt=10", out_valid, f, $time - t0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    stale     = 0;
    out_ready = 1'b1;
    send(OP_MUL, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, f, f_hi, flags} !== 21'h0) begin
      failures++;
      $display("FAIL mid_mul_reset got ov=%b f=%h f_hi=%h flags=%b want all 0", out_valid, f, f_hi, flags);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_mul_in_ready got=%b want=1", in_ready);
    end
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL mid_mul_stale got %0d valid cycles want 0", stale);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit done_rand;
    done_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
          end
          send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL random_drain got %0d outstanding want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_flag_corners();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
